// File: rtl/q_measure_pkg.sv
// q_measure_pkg: shared types and constants for the Q measurement front-end.
//   q_meas_state_t : FSM state encoding (SETTLE, ACCUM, DONE)
//   SETTLE_CNT_W   : width of the settling-time counter
package q_measure_pkg;

  typedef enum logic [1:0] {SETTLE, ACCUM, DONE} q_meas_state_t;

  localparam int SETTLE_CNT_W = 8;

endpackage

// File: rtl/q_measure.sv
// q_measure: measurement front-end for the secant/bisection current controller.
// Every change of i_ref restarts a measurement. The block waits SETTLE_CYCLES,
// then averages 2^AVG_LOG2 raw Q samples. The result is shown on measured_q,
// and ready is raised while that value belongs to the current i_ref.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   i_ref        in   [WIDTH] current reference applied by the controller
//   sample_valid in   qualifies sample_q for one cycle
//   sample_q     in   [WIDTH] raw unsigned Q estimate
//   measured_q   out  [WIDTH] averaged Q for the current i_ref
//   ready        out  measured_q is valid for the current i_ref
//   busy         out  measurement in progress (SETTLE or ACCUM)
module q_measure
  import q_measure_pkg::*;
#(
  parameter int WIDTH         = 10,
  parameter int SETTLE_CYCLES = 8,
  parameter int AVG_LOG2      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_ref,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample_q,
  output logic [WIDTH-1:0] measured_q,
  output logic             ready,
  output logic             busy
);

  localparam int ACC_W  = WIDTH + AVG_LOG2;
  localparam int SAMP_W = AVG_LOG2 + 1;
  localparam logic [SETTLE_CNT_W-1:0] LAST_SETTLE = SETTLE_CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [SAMP_W-1:0]       LAST_SAMP   = SAMP_W'((1 << AVG_LOG2) - 1);

  q_meas_state_t           state_q;
  logic [SETTLE_CNT_W-1:0] settle_cnt_q;
  logic [SAMP_W-1:0]       samp_cnt_q;
  logic [ACC_W-1:0]        acc_q;
  logic [ACC_W-1:0]        acc_d;
  logic [WIDTH-1:0]        measured_q_q;
  logic                    ready_q;
  logic [WIDTH-1:0]        i_ref_last_q;
  logic                    chg;

  // Truncating average: plain shift, no rounding.
  function automatic logic [WIDTH-1:0] avg_trunc(input logic [ACC_W-1:0] sum);
    return WIDTH'(sum >> AVG_LOG2);
  endfunction

  assign chg   = (i_ref != i_ref_last_q);
  // acc is sized so that 2^AVG_LOG2 full-scale samples cannot overflow it.
  assign acc_d = acc_q + ACC_W'(sample_q);

  // Stage boundary: the change-detect, FSM and accumulator are registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      // Load i_ref_last from the live input so leaving reset does not look like a change.
      i_ref_last_q <= i_ref;
      state_q      <= SETTLE;
      settle_cnt_q <= '0;
      samp_cnt_q   <= '0;
      acc_q        <= '0;
      measured_q_q <= '0;
      ready_q      <= 1'b0;
    end else if (chg) begin
      // A new reference overrides everything. Old Q data is never reused.
      i_ref_last_q <= i_ref;
      state_q      <= SETTLE;
      settle_cnt_q <= '0;
      samp_cnt_q   <= '0;
      acc_q        <= '0;
      ready_q      <= 1'b0;
    end else begin
      case (state_q)
        SETTLE: begin
          if (settle_cnt_q == LAST_SETTLE) state_q <= ACCUM;
          else settle_cnt_q <= settle_cnt_q + 1'b1;
        end
        ACCUM: begin
          if (sample_valid) begin
            acc_q      <= acc_d;
            samp_cnt_q <= samp_cnt_q + 1'b1;
            if (samp_cnt_q == LAST_SAMP) begin
              measured_q_q <= avg_trunc(acc_d);
              ready_q      <= 1'b1;
              state_q      <= DONE;
            end
          end
        end
        DONE: ;
        default: state_q <= SETTLE;
      endcase
    end
  end

  assign measured_q = measured_q_q;
  assign ready      = ready_q;
  assign busy       = (state_q != DONE);

endmodule

// File: doc/q_measure.md
Name: q_measure

Overview:
- Measurement front-end directly upstream of the secant/bisection current controller.
- Watches the controller's i_ref. On every i_ref change it waits a fixed settling time, then averages 2^AVG_LOG2 raw Q samples from the sensor path.
- Presents the averaged result as measured_q, together with a level-sensitive ready that drives the controller's ready input.
- Guarantees the controller never iterates on a Q value taken before the current i_ref took effect.

Parameters:
- WIDTH, 10, bit width of i_ref, sample_q and measured_q.
- SETTLE_CYCLES, 8, clk cycles ignored after an i_ref change; legal range 1..255.
- AVG_LOG2, 2, log2 of the number of samples averaged (4); legal range 0..4.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- i_ref  input  WIDTH  current reference currently applied by the controller.
- sample_valid  input  1  qualifies sample_q for one cycle.
- sample_q  input  WIDTH  raw unsigned Q estimate from the sensor path.
- measured_q  output  WIDTH  averaged Q for the current i_ref.
- ready  output  1  high while measured_q is valid for the current i_ref.
- busy  output  1  high in SETTLE or ACCUM.

Behaviour:
- Reset (rst=1 at an edge):
  - state=SETTLE, settle_cnt=0, samp_cnt=0, acc=0.
  - measured_q=0, ready=0.
  - i_ref_last is loaded with i_ref, so reset does not cause a spurious extra restart.
- Change detect:
  - chg = (i_ref != i_ref_last), combinational.
  - At any edge with chg=1, in any state: i_ref_last<=i_ref, state<=SETTLE, settle_cnt<=0, samp_cnt<=0, acc<=0, ready<=0.
  - measured_q holds its old value but is invalid while ready=0.
  - chg has priority over every other transition.
- SETTLE:
  - sample_valid is ignored.
  - If settle_cnt==SETTLE_CYCLES-1, go to ACCUM; otherwise settle_cnt++.
  - SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- ACCUM:
  - On sample_valid: acc<=acc+sample_q and samp_cnt++.
  - On the sample where samp_cnt==2^AVG_LOG2-1:
    - measured_q<=(acc+sample_q)>>AVG_LOG2, truncating (no rounding);
    - ready<=1;
    - state<=DONE.
  - Cycles without sample_valid stall; there is no timeout.
- DONE:
  - measured_q and ready hold.
  - sample_valid is ignored.
  - Exit only via chg or rst.
- Width rules:
  - acc is WIDTH+AVG_LOG2 bits, unsigned, and cannot overflow.
  - settle_cnt is 8 bits; samp_cnt is AVG_LOG2+1 bits.
- Latency:
  - An i_ref change first visible in cycle t, with sample_valid held high, gives ready=1 from cycle t+1+SETTLE_CYCLES+2^AVG_LOG2.
  - With defaults this is t+13.
- busy = (state != DONE), registered-state decode. It is 1 out of reset.
- Boundary conditions:
  - chg coincident with the final sample: the sample is discarded, ready stays 0 and the measurement restarts.
  - AVG_LOG2=0: a single sample passes through unchanged.
  - rst mid-ACCUM: all state is cleared as on reset, and measured_q becomes 0.
  - i_ref toggling faster than SETTLE_CYCLES: ready never asserts.

Decomposition:
- Package q_measure_pkg holds:
  - typedef enum logic [1:0] {SETTLE, ACCUM, DONE} q_meas_state_t;
  - localparam SETTLE_CNT_W = 8.
- No sub-module is needed; change detect, FSM and accumulator stay in one file.
- An optional sub-module q_avg_accum (accumulate/shift/count) is acceptable if reuse is wanted.

Test Plan:
- Reset release with i_ref=512 held and sample_valid=1, sample_q=145 constant:
  - busy=1 and ready=0 for cycles 0..11;
  - ready=1 and measured_q=145 from cycle 12 (no chg; SETTLE starts at reset);
  - busy=0 from the same cycle.
- Averaging with sample_q sequence 100,101,102,104 after settling -> measured_q=101 (407>>2, truncated).
- Samples during settle: sample_q=1023 during SETTLE, then 50 ×4 -> measured_q=50, and the settle samples are provably ignored.
- Mid-measurement change: i_ref 512->256 after 2 accumulated samples -> ready stays 0, busy=1, and ready rises exactly 13 cycles after the change with the new average only.
- Simultaneous chg and final sample -> no update; ready=0 until a fresh 8+4 sequence completes.
- Stall: sample_valid pulsed every 3rd cycle -> ready asserts after the 4th valid sample. Then rst=1 for one cycle in DONE -> measured_q=0, ready=0, busy=1 on the next cycle.
